// File: rtl/fetch_stage_pkg.sv
// Shared constants, state encoding and IF/ID payload for the fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned IMEM_WORDS      = 128;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_WORD         = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    // Word-align a branch/jump target before it enters the PC.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] target);
        return {target[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, memory address and IF/ID register out.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] ifid_instruction;
    logic [XLEN-1:0] ifid_pc_plus4;
    logic            ifid_valid;
    logic            halted;

    modport master (
        input  stall, redirect, redirect_target, instruction,
        output address, ifid_instruction, ifid_pc_plus4, ifid_valid, halted
    );

    modport slave (
        output stall, redirect, redirect_target, instruction,
        input  address, ifid_instruction, ifid_pc_plus4, ifid_valid, halted
    );

endinterface

// File: rtl/fetch_stage_ifid_register.sv
// IF/ID pipeline latch: flush inserts a bubble, load captures, hold (or idle) keeps.
module ifid_register
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP = NOP_WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  logic            hold,
    input  logic [XLEN-1:0] instruction_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    output ifid_t           q
);

    // A bubble keeps the previous PC+4 so only the instruction and valid bit change.
    always_ff @(posedge clk) begin
        if (reset) begin
            q.instruction <= NOP;
            q.pc_plus4    <= '0;
            q.valid       <= 1'b0;
        end else if (flush) begin
            q.instruction <= NOP;
            q.valid       <= 1'b0;
        end else if (load && !hold) begin
            q.instruction <= instruction_in;
            q.pc_plus4    <= pc_plus4_in;
            q.valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, next-PC selection, RUN/HALT control and the IF/ID register.
// Optional build macro FETCH_DELAY_SLOT_EN keeps the delay-slot word on a redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int unsigned     IMEM_DEPTH     = IMEM_WORDS,
    parameter logic [XLEN-1:0] NOP            = NOP_WORD
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    localparam logic [XLEN-1:0] IMEM_BYTES = XLEN'(IMEM_DEPTH * 4);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_pc;
    logic            in_range;
    fetch_state_t    state;
    logic            ifid_load;
    logic            ifid_flush;
    logic            ifid_hold;
    ifid_t           ifid;

    assign pc_plus4    = pc + XLEN'(4);
    assign in_range    = (pc < IMEM_BYTES);
    assign redirect_pc = align_word(bus.redirect_target);

    // IF/ID control; priority is halt, redirect, stall, then normal advance.
    always_comb begin
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_hold  = 1'b0;
        if (state == HALT) begin
            ifid_flush = 1'b1;
        end else if (bus.redirect) begin
`ifdef FETCH_DELAY_SLOT_EN
            if (bus.stall) begin
                ifid_hold = 1'b1;
            end else if (in_range) begin
                ifid_load = 1'b1;
            end else begin
                ifid_flush = 1'b1;
            end
`else
            ifid_flush = 1'b1;
`endif
        end else if (bus.stall) begin
            ifid_hold = 1'b1;
        end else if (in_range) begin
            ifid_load = 1'b1;
        end else begin
            ifid_flush = 1'b1;
        end
    end

    // PC and fetch state; HALT is left only through reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            state <= RUN;
        end else if (state == RUN) begin
            if (bus.redirect) begin
                pc <= redirect_pc;
            end else if (!bus.stall) begin
                if (in_range) begin
                    pc <= pc_plus4;
                end else begin
                    state <= HALT;
                end
            end
        end
    end

    ifid_register #(
        .NOP (NOP)
    ) u_ifid (
        .clk            (clk),
        .reset          (reset),
        .load           (ifid_load),
        .flush          (ifid_flush),
        .hold           (ifid_hold),
        .instruction_in (bus.instruction),
        .pc_plus4_in    (pc_plus4),
        .q              (ifid)
    );

    assign bus.address          = pc;
    assign bus.ifid_instruction = ifid.instruction;
    assign bus.ifid_pc_plus4    = ifid.pc_plus4;
    assign bus.ifid_valid       = ifid.valid;
    assign bus.halted           = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/redirect/reset
// traffic against a cycle-level behavioural model. Honours FETCH_DELAY_SLOT_EN.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] mem [128];

    int unsigned n_checks;
    int unsigned n_pass;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_halted;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Combinational instruction memory; out-of-range reads return a marker word.
    assign bus.instruction = (bus.address < 32'd512) ? mem[bus.address[8:2]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("address",     bus.address,          m_pc);
        check("ifid_instr",  bus.ifid_instruction, m_instr);
        check("ifid_pc4",    bus.ifid_pc_plus4,    m_pc4);
        check("ifid_valid",  {31'b0, bus.ifid_valid}, {31'b0, m_valid});
        check("halted",      {31'b0, bus.halted},     {31'b0, m_halted});
    endtask

    // Next-cycle architectural state from the fetch rules, applied to pre-edge model state.
    task automatic model_update(input logic rst, input logic st, input logic rd, input logic [31:0] tgt);
        logic        ok;
        logic [31:0] fetched;
        logic [31:0] idx;
        ok      = (m_pc < 32'd512);
        idx     = m_pc >> 2;
        fetched = ok ? mem[idx[6:0]] : 32'hDEAD_BEEF;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
            m_instr = 32'h0; m_valid = 1'b0;
        end else if (rd) begin
`ifdef FETCH_DELAY_SLOT_EN
            if (!st) begin
                if (ok) begin
                    m_instr = fetched; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                end else begin
                    m_instr = 32'h0; m_valid = 1'b0;
                end
            end
`else
            m_instr = 32'h0; m_valid = 1'b0;
`endif
            m_pc = tgt & 32'hFFFF_FFFC;
        end else if (!st) begin
            if (ok) begin
                m_instr = fetched; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end else begin
                m_instr = 32'h0; m_valid = 1'b0; m_halted = 1'b1;
            end
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] tgt);
        reset               = rst;
        bus.stall           = st;
        bus.redirect        = rd;
        bus.redirect_target = tgt;
        model_update(rst, st, rd, tgt);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int guard;
        n_checks = 0;
        n_pass   = 0;
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0;
        reset = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 32'h0;
        for (int i = 0; i < 128; i++) mem[i] = 32'(4 * i);

        // Reset values and first fetches.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("rst_addr", bus.address, 32'h0);
        check("rst_valid", {31'b0, bus.ifid_valid}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("seq_addr8", bus.address, 32'h8);
        check("seq_instr4", bus.ifid_instruction, 32'h4);
        check("seq_pc4_8", bus.ifid_pc_plus4, 32'h8);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // Stall for three cycles at address 16.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        check("stall_addr", bus.address, 32'd16);
        check("stall_instr", bus.ifid_instruction, 32'd12);
        check("stall_pc4", bus.ifid_pc_plus4, 32'd16);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("release_addr", bus.address, 32'd20);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect at address 24 to an unaligned target.
        step(1'b0, 1'b0, 1'b1, 32'h43);
        check("redir_addr", bus.address, 32'h40);
`ifdef FETCH_DELAY_SLOT_EN
        check("redir_slot_instr", bus.ifid_instruction, 32'd24);
        check("redir_slot_valid", {31'b0, bus.ifid_valid}, 32'h1);
`else
        check("redir_flush_instr", bus.ifid_instruction, 32'h0);
        check("redir_flush_valid", {31'b0, bus.ifid_valid}, 32'h0);
`endif

        // Redirect together with stall at address 8.
        step(1'b0, 1'b0, 1'b1, 32'h8);
        step(1'b0, 1'b1, 1'b1, 32'h100);
        check("redir_stall_addr", bus.address, 32'h100);

        // Run off the end of memory into HALT.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        guard = 0;
        while (m_pc != 32'd508 && guard < 200) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            guard++;
        end
        check("reach_508", bus.address, 32'd508);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("end_addr", bus.address, 32'd512);
        check("end_not_halted", {31'b0, bus.halted}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("halt_flag", {31'b0, bus.halted}, 32'h1);
        check("halt_valid", {31'b0, bus.ifid_valid}, 32'h0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'(i == 4), 32'h20);
        check("halt_addr_hold", bus.address, 32'd512);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("halt_reset_flag", {31'b0, bus.halted}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("resume_addr", bus.address, 32'h4);

        // Reset in the middle of a stall, with a redirect present.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h80);
        check("midstall_reset_addr", bus.address, 32'h0);

        // Wrap-around target is out of range and halts on the next advance.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_halt", {31'b0, bus.halted}, 32'h1);

        // Randomized traffic with random memory contents.
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst;
            logic        r_st;
            logic        r_rd;
            logic [31:0] r_tgt;
            r_rst = m_halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 199) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_rd  = ($urandom_range(0, 9) == 0);
            r_tgt = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 520));
            step(r_rst, r_st, r_rd, r_tgt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
